// File: rtl/debug_in_mailbox.sv
// Inbound host-to-CPU debug mailbox: host pushes 32-bit words into a FIFO, CPU pops them over the peripheral bus.
// Optional interrupt output and enable bit are compiled in with DEBUG_IN_IRQ_EN.
module debug_in_mailbox #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  input  logic        we,
  input  logic        re,
  input  logic        host_valid,
  input  logic [31:0] host_data,
`ifdef DEBUG_IN_IRQ_EN
  output logic        irq,
`endif
  output logic        host_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;
  logic          underflow;
  logic          empty;
  logic          full;
  logic          pop_req;
  logic          ctrl_wr;
  logic          flush;
  logic          clr_uf;
  logic          push;
  logic          pop;
  logic          uf_set;
  logic          status_irq_en;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_req = re && (address == 8'h00);
  assign ctrl_wr = we && (address == 8'h08);
  assign flush   = ctrl_wr && write_data[0];
  assign clr_uf  = ctrl_wr && write_data[1];

  // Flush outranks both sides: the push is refused and the pop is silently dropped.
  assign host_ready = !full && !flush;
  assign push       = host_valid && host_ready;
  assign pop        = pop_req && !empty && !flush;
  assign uf_set     = pop_req && empty && !flush;

  always_comb begin
    count_next = count;
    if (flush) begin
      count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   count_next = count + CW'(1);
        2'b01:   count_next = count - CW'(1);
        default: count_next = count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      underflow <= 1'b0;
    end else begin
      count <= count_next;
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
      end
      if (uf_set) underflow <= 1'b1;
      else if (clr_uf) underflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= host_data;
  end

`ifdef DEBUG_IN_IRQ_EN
  logic irq_en;
  logic [28:0] unused_write_bits;
  assign unused_write_bits = write_data[31:3];

  // irq is computed from the enable held before this edge's CONTROL write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_en <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en <= write_data[2];
      irq <= irq_en && (count_next != '0);
    end
  end
  assign status_irq_en = irq_en;
`else
  logic [29:0] unused_write_bits;
  assign unused_write_bits = write_data[31:2];
  assign status_irq_en = 1'b0;
`endif

  always_comb begin
    read_data = 32'h0;
    case (address)
      8'h00: read_data = empty ? 32'h0 : mem[rd_ptr];
      8'h04: read_data = {16'h0, 8'(count), 4'h0, status_irq_en, underflow, full, !empty};
      default: read_data = 32'h0;
    endcase
  end

endmodule
